// File: rtl/fp_log2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_log2_pkg
//  Description : Shared types, status bit indices and parameter helper
//                functions for the sequential floating-point log2 unit.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_log2_pkg;

  // Control states of the sequential log2 engine.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  // Bit positions inside the 8-bit status word.
  localparam int STAT_ZERO    = 0;
  localparam int STAT_INF     = 1;
  localparam int STAT_INVALID = 2;
  localparam int STAT_INEXACT = 5;
  localparam int STAT_DIVZ    = 7;

  // Exponent bias for an exp_width-bit exponent field.
  function automatic int calc_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // Number of internal fraction bits carried through the squaring loop.
  function automatic int calc_frac_w(input int sw, input int ep);
    return sw + ep + 4;
  endfunction

  // One fraction bit is produced per iteration.
  function automatic int calc_iter_n(input int sw, input int ep);
    return calc_frac_w(sw, ep);
  endfunction

  // Infinity encoding (all-ones exponent, zero significand), returned in
  // the low sw+ew+1 bits of a 64-bit word.
  function automatic logic [63:0] inf_bits(input int sw, input int ew, input logic neg);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < ew; i++) begin
      r[sw + i] = 1'b1;
    end
    r[sw + ew] = neg;
    return r;
  endfunction

  // Canonical quiet NaN: positive, all-ones exponent, significand MSB set.
  function automatic logic [63:0] qnan_bits(input int sw, input int ew);
    logic [63:0] r;
    r = inf_bits(sw, ew, 1'b0);
    r[sw - 1] = 1'b1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_log2_norm_round.sv
`default_nettype none
// ============================================================================
//  Module      : fp_log2_norm_round
//  Description : Combinational fixed-point to floating-point conversion.
//                Takes a sign/magnitude fixed value (exp_width integer bits,
//                frac_bits fraction bits) plus an external sticky bit,
//                normalises it with a leading-zero count and rounds to
//                nearest-even.
//  Ports       : sign       - sign of the value
//                mag        - unsigned magnitude, binary point frac_bits up
//                sticky_in  - value has nonzero bits below the magnitude LSB
//                z          - packed {sign, exp, sig} result
//                inexact    - any discarded bit was nonzero
//                zero       - magnitude is zero (z is +0)
//  Revision    : 1.0  initial release
// ============================================================================
module fp_log2_norm_round
  import fp_log2_pkg::*;
#(
  parameter int sig_width = 10,
  parameter int exp_width = 5,
  parameter int frac_bits = 14,
  localparam int FW  = exp_width + frac_bits,
  localparam int TW  = sig_width + exp_width + 1
) (
  input  logic          sign,
  input  logic [FW-1:0] mag,
  input  logic          sticky_in,
  output logic [TW-1:0] z,
  output logic          inexact,
  output logic          zero
);

  localparam int BIAS = calc_bias(exp_width);
  localparam int LZW  = $clog2(FW + 1);
  // Biased exponent of a value whose leading one sits at the magnitude MSB.
  localparam int EXP_TOP = FW - 1 - frac_bits + BIAS;

  function automatic logic [LZW-1:0] lzc(input logic [FW-1:0] v);
    logic [LZW-1:0] n;
    logic           found;
    n     = LZW'(FW);
    found = 1'b0;
    for (int i = FW - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = LZW'(FW - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic [LZW-1:0]       lz;
  logic [FW-1:0]        norm;
  logic [sig_width-1:0] mant;
  logic                 guard;
  logic                 sticky;
  logic                 round_up;
  logic [sig_width:0]   mant_r;
  logic [exp_width-1:0] exp_b;

  always_comb begin
    lz       = lzc(mag);
    norm     = mag << lz;
    // norm[FW-1] is the hidden one; the stored significand follows it.
    mant     = norm[FW-2 -: sig_width];
    guard    = norm[FW-2-sig_width];
    sticky   = (|norm[FW-3-sig_width:0]) | sticky_in;
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + (sig_width + 1)'(round_up);
    // A rounding carry out of the significand bumps the exponent; the
    // stored significand bits are then all zero.
    exp_b    = exp_width'(EXP_TOP) - exp_width'(lz) + exp_width'(mant_r[sig_width]);
    inexact  = guard | sticky;
    zero     = !norm[FW-1];
    if (zero) begin
      z = '0;
    end else begin
      z = {sign, exp_b, mant_r[sig_width-1:0]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_log2_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp_log2_seq
//  Description : Multi-cycle floating-point base-2 logarithm. Fraction bits
//                of log2(1.sig) come from a square-and-compare loop, one bit
//                per cycle; a final normalise/round cycle packs the result.
//                One operand in flight, valid/ready on both sides.
//  Ports       : clk, rst_n          - clock, asynchronous active-low reset
//                in_valid, in_ready  - operand handshake
//                a                   - operand {sign, exp, sig}
//                out_valid, out_ready- result handshake
//                z                   - log2(a)
//                status              - [0] zero [1] inf [2] invalid
//                                      [5] inexact [7] divide-by-zero
//  Options     : FP_LOG2_EARLY_TERM_EN - leave the loop as soon as the
//                remaining fraction bits are known to be zero.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_log2_seq
  import fp_log2_pkg::*;
#(
  parameter int sig_width       = 10,
  parameter int exp_width       = 5,
  parameter int extra_prec      = 0,
  parameter int ieee_compliance = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [sig_width+exp_width:0]   a,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [sig_width+exp_width:0]   z,
  output logic [7:0]                     status
);

  localparam int TW     = sig_width + exp_width + 1;
  localparam int BIAS   = calc_bias(exp_width);
  localparam int W      = calc_frac_w(sig_width, extra_prec);
  localparam int ITER_N = calc_iter_n(sig_width, extra_prec);
  localparam int FW     = exp_width + W;

  localparam logic [63:0]        QNAN64    = qnan_bits(sig_width, exp_width);
  localparam logic [63:0]        PINF64    = inf_bits(sig_width, exp_width, 1'b0);
  localparam logic [63:0]        NINF64    = inf_bits(sig_width, exp_width, 1'b1);
  localparam logic [TW-1:0]      QNAN      = QNAN64[TW-1:0];
  localparam logic [TW-1:0]      POS_INF   = PINF64[TW-1:0];
  localparam logic [TW-1:0]      NEG_INF   = NINF64[TW-1:0];
  localparam logic [exp_width:0] BIAS_E    = (exp_width + 1)'(BIAS);
  localparam logic [W:0]         ONE       = {1'b1, {W{1'b0}}};
  // Only the flush-to-zero mode exists: subnormal operands behave as zero.
  localparam logic               FLUSH_SUB = (ieee_compliance == 0);

  // --------------------------------------------------------------------------
  // Operand decode and special-case selection
  // --------------------------------------------------------------------------
  logic                 a_sign;
  logic [exp_width-1:0] a_exp;
  logic [sig_width-1:0] a_sig;
  logic                 special;
  logic [TW-1:0]        spec_z;
  logic [7:0]           spec_status;

  assign a_sign = a[TW-1];
  assign a_exp  = a[TW-2:sig_width];
  assign a_sig  = a[sig_width-1:0];

  always_comb begin
    special     = 1'b1;
    spec_z      = QNAN;
    spec_status = '0;
    if ((&a_exp) && (a_sig != '0)) begin
      spec_status[STAT_INVALID] = 1'b1;
    end else if ((a_exp == '0) && (FLUSH_SUB || (a_sig == '0))) begin
      spec_z                 = NEG_INF;
      spec_status[STAT_INF]  = 1'b1;
      spec_status[STAT_DIVZ] = 1'b1;
    end else if (a_sign) begin
      spec_status[STAT_INVALID] = 1'b1;
    end else if (&a_exp) begin
      spec_z                = POS_INF;
      spec_status[STAT_INF] = 1'b1;
    end else begin
      special = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  state_t      state;
  state_t      state_nxt;
  logic [W:0]  y;           // 1.xxx fixed point, W fraction bits
  logic [W-1:0] frac;       // log2 fraction bits, MSB first
  logic [ITER_N-1:0] mask;  // one-hot: fraction bit written this cycle
  logic [exp_width:0] e_reg;// unbiased exponent, two's complement
  logic        sticky;      // truncation seen in the squaring loop
  logic [TW-1:0] z_reg;
  logic [7:0]  status_reg;
  logic        early;

`ifdef FP_LOG2_EARLY_TERM_EN
  // y == 1.0 with nothing ever truncated means every later square is 1.0
  // and every remaining fraction bit is zero.
  assign early = (y == ONE) && !sticky;
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = special ? DONE : ITER;
        end
      end
      ITER: begin
        if (early || mask[0]) begin
          state_nxt = NORM;
        end
      end
      NORM: begin
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Squaring step: log2(y^2) = 2*log2(y), so a square reaching 2 yields the
  // next fraction bit as 1 and is halved back into [1,2).
  // --------------------------------------------------------------------------
  logic [2*W+1:0] sq;
  logic           sq_ge2;
  logic [W:0]     y_sq;
  logic           trunc;

  always_comb begin
    sq     = {{(W+1){1'b0}}, y} * {{(W+1){1'b0}}, y};
    sq_ge2 = sq[2*W+1];
    if (sq_ge2) begin
      y_sq  = sq[2*W+1:W+1];
      trunc = |sq[W:0];
    end else begin
      y_sq  = sq[2*W:W];
      trunc = |sq[W-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // Fixed value V = E + 0.frac as sign/magnitude. The true value lies
  // strictly above V when anything is left over, so a negative V with a
  // remainder has magnitude ~V plus a nonzero tail rather than -V.
  // --------------------------------------------------------------------------
  logic [FW-1:0] v_low;
  logic          neg;
  logic          rem;
  logic [FW-1:0] mag;
  logic [TW-1:0] nr_z;
  logic          nr_inexact;
  logic          nr_zero;
  logic [7:0]    norm_status;

  always_comb begin
    v_low = {e_reg[exp_width-1:0], frac};
    neg   = e_reg[exp_width];
    rem   = sticky | (y != ONE);
    if (!neg) begin
      mag = v_low;
    end else if (rem) begin
      mag = ~v_low;
    end else begin
      mag = ~v_low + FW'(1);
    end
  end

  fp_log2_norm_round #(
    .sig_width (sig_width),
    .exp_width (exp_width),
    .frac_bits (W)
  ) u_norm_round (
    .sign      (neg),
    .mag       (mag),
    .sticky_in (rem),
    .z         (nr_z),
    .inexact   (nr_inexact),
    .zero      (nr_zero)
  );

  always_comb begin
    norm_status               = '0;
    norm_status[STAT_ZERO]    = nr_zero;
    norm_status[STAT_INEXACT] = nr_inexact;
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y          <= '0;
      frac       <= '0;
      mask       <= '0;
      e_reg      <= '0;
      sticky     <= 1'b0;
      z_reg      <= '0;
      status_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (special) begin
              z_reg      <= spec_z;
              status_reg <= spec_status;
            end else begin
              y      <= {1'b1, a_sig, {(W-sig_width){1'b0}}};
              frac   <= '0;
              mask   <= {1'b1, {(ITER_N-1){1'b0}}};
              e_reg  <= {1'b0, a_exp} - BIAS_E;
              sticky <= 1'b0;
            end
          end
        end
        ITER: begin
          if (!early) begin
            y      <= y_sq;
            sticky <= sticky | trunc;
            mask   <= mask >> 1;
            if (sq_ge2) begin
              frac <= frac | mask;
            end
          end
        end
        NORM: begin
          z_reg      <= nr_z;
          status_reg <= norm_status;
        end
        default: begin
        end
      endcase
    end
  end

  assign z      = z_reg;
  assign status = status_reg;

endmodule
`default_nettype wire
